// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int MUL_LAT  = 3;
    // Widest value cond_neg handles; callers zero-extend in and slice out.
    localparam int NEG_MAXW = 256;

    typedef logic [NEG_MAXW-1:0] neg_word_t;

    // The low N bits of the result are the N-bit two's complement of the low N bits of v.
    function automatic neg_word_t cond_neg(input neg_word_t v, input logic neg);
        return neg ? (~v + neg_word_t'(1)) : v;
    endfunction

endpackage

// File: rtl/ve_half_mul.sv
// Combinational H x H -> 2H unsigned multiplier used for the four partial products.
module ve_half_mul #(
    parameter int H = 32
) (
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    assign p_o = {{H{1'b0}}, a_i} * {{H{1'b0}}, b_i};

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage valid/ready Vedic multiplier: sign/magnitude, quadrant products, combine/negate.
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || PW >= NEG_MAXW) begin : g_bad_width
        $error("vedic_mul_pipe: WIDTH must be even, >= 4 and below NEG_MAXW/2");
    end

    // ---------------- stage occupancy and advance chain ----------------
    logic [MUL_LAT:1] vld_q, vld_d;
    logic             en1, en2, en3;
    logic             ld1, ld2, ld3;

    // A stage may take new contents when empty or when its successor drains it.
    always_comb begin
        en3   = !vld_q[3] || out_ready;
        en2   = !vld_q[2] || en3;
        en1   = !vld_q[1] || en2;
        ld1   = en1 && in_valid;
        ld2   = en2 && vld_q[1];
        ld3   = en3 && vld_q[2];
        vld_d = vld_q;
        if (en1) vld_d[1] = in_valid;
        if (en2) vld_d[2] = vld_q[1];
        if (en3) vld_d[3] = vld_q[2];
    end

    assign in_ready = rst_n && en1;

    // ---------------- S1: operand magnitudes ----------------
    neg_word_t          a_ext, b_ext;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d;
    logic               neg1_d;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q;
    logic               neg1_q;
    logic [TAG_W-1:0]   tag1_q;

    // Most negative input maps to 2^(W-1), which still fits unsigned in W bits.
    assign a_ext   = cond_neg(neg_word_t'(in_a), in_signed & in_a[WIDTH-1]);
    assign b_ext   = cond_neg(neg_word_t'(in_b), in_signed & in_b[WIDTH-1]);
    assign a_mag_d = a_ext[WIDTH-1:0];
    assign b_mag_d = b_ext[WIDTH-1:0];
    assign neg1_d  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    // ---------------- S2: quadrant partial products ----------------
    logic [WIDTH-1:0]   ll_d, lh_d, hl_d, hh_d;
    logic [WIDTH-1:0]   ll_q, lh_q, hl_q, hh_q;
    logic               neg2_q;
    logic [TAG_W-1:0]   tag2_q;

    ve_half_mul #(.H(H)) u_ll (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[H-1:0]),     .p_o(ll_d));
    ve_half_mul #(.H(H)) u_lh (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[WIDTH-1:H]), .p_o(lh_d));
    ve_half_mul #(.H(H)) u_hl (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[H-1:0]),     .p_o(hl_d));
    ve_half_mul #(.H(H)) u_hh (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[WIDTH-1:H]), .p_o(hh_d));

    // ---------------- S3: combine and restore sign ----------------
    logic [PW-1:0]      prod_d, res_d, res_q;
    neg_word_t          r_ext;
    logic [TAG_W-1:0]   tag3_q;
    logic               unused_neg_hi;

    // hh and ll do not overlap, so they concatenate; the cross terms are summed at full width.
    assign prod_d = {hh_q, ll_q} + ((PW'(lh_q) + PW'(hl_q)) << H);
    assign r_ext  = cond_neg(neg_word_t'(prod_d), neg2_q);
    assign res_d  = r_ext[PW-1:0];

    assign unused_neg_hi = ^{a_ext[NEG_MAXW-1:WIDTH], b_ext[NEG_MAXW-1:WIDTH], r_ext[NEG_MAXW-1:PW]};

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            res_q  <= '0;
            tag3_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (ld3) begin
                res_q  <= res_d;
                tag3_q <= tag2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld1) begin
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg1_q  <= neg1_d;
            tag1_q  <= in_tag;
        end
        if (ld2) begin
            ll_q   <= ll_d;
            lh_q   <= lh_d;
            hl_q   <= hl_d;
            hh_q   <= hh_d;
            neg2_q <= neg1_q;
            tag2_q <= tag1_q;
        end
    end

    assign out_valid  = vld_q[3];
    assign out_result = res_q;
    assign out_tag    = tag3_q;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe: directed 64-bit corners/flow tests and randomized 8-bit scoreboard.
module tb_vedic_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         iv, ir, ov, ordy, sg;
    logic [63:0]  a, b;
    logic [3:0]   tg, otg;
    logic [127:0] ores;

    logic         iv8, ir8, ov8, ordy8, sg8;
    logic [7:0]   a8, b8;
    logic [3:0]   tg8, otg8;
    logic [15:0]  ores8;

    int n_chk = 0;
    int n_err = 0;

    vedic_mul_pipe #(.WIDTH(64), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b), .in_signed(sg), .in_tag(tg),
        .out_valid(ov), .out_ready(ordy), .out_result(ores), .out_tag(otg)
    );

    vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_signed(sg8), .in_tag(tg8),
        .out_valid(ov8), .out_ready(ordy8), .out_result(ores8), .out_tag(otg8)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as integers of the chosen signedness and multiply.
    function automatic logic [127:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [127:0] ex, ey;
        ex = s ? {{64{x[63]}}, x} : {64'd0, x};
        ey = s ? {{64{y[63]}}, y} : {64'd0, y};
        return ex * ey;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ix, iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe and check it appears on the third edge after presentation.
    task automatic run1(input string nm, input logic [63:0] x, input logic [63:0] y,
                        input logic s, input logic [3:0] t, input logic [127:0] exp);
        ordy = 1'b1; a = x; b = y; sg = s; tg = t; iv = 1'b1;
        @(negedge clk); chk({nm, "_rdy"}, ir, 1);
        tick(); iv = 1'b0;
        @(negedge clk); chk({nm, "_lat1"}, ov, 0);
        tick();
        @(negedge clk); chk({nm, "_lat2"}, ov, 0);
        tick();
        @(negedge clk); chk({nm, "_valid"}, ov, 1);
        chk({nm, "_res"}, ores, exp);
        chk({nm, "_tag"}, otg, t);
        tick();
        @(negedge clk); chk({nm, "_drain"}, ov, 0);
        tick();
    endtask

    // 8-bit scoreboard
    logic         mon8 = 1'b0;
    logic [15:0]  q8r[$];
    logic [3:0]   q8t[$];

    always @(negedge clk) begin
        if (mon8 && rst_n) begin
            if (iv8 && ir8) begin
                q8r.push_back(ref8(a8, b8, sg8));
                q8t.push_back(tg8);
            end
            if (ov8 && ordy8) begin
                if (q8r.size() == 0) chk("w8_extra", 1, 0);
                else begin
                    chk("w8_res", ores8, q8r.pop_front());
                    chk("w8_tag", otg8, q8t.pop_front());
                end
            end
        end
    end

    logic [63:0]  bp_a[8], bp_b[8];
    logic         bp_s[8];
    logic [127:0] eq_r[$];
    logic [3:0]   eq_t[$];
    logic [127:0] hold_r;
    logic [3:0]   hold_t;
    logic         hold_v;
    int           sent, got, acc;

    initial begin
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; sg = 1'b0; tg = '0;
        iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; sg8 = 1'b0; tg8 = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ov", ov, 0);
        chk("rst_ir", ir, 0);
        chk("rst_res", ores, 0);
        chk("rst_tag", otg, 0);
        chk("rst_ov8", ov8, 0);
        tick();
        rst_n = 1'b1;

        // ---- corners ----
        run1("u_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h5,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run1("s_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'hA,
             128'h4000_0000_0000_0000_0000_0000_0000_0000);
        run1("s_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 4'h3,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        run1("u_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 4'hC,
             128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1);
        run1("s_m3xm5", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 4'h7, 128'd15);

        // ---- backpressure: out_ready low on cycles 2..7 ----
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = {$urandom, $urandom};
            bp_b[i] = {$urandom, $urandom};
            bp_s[i] = 1'($urandom);
        end
        sent = 0; got = 0; hold_v = 1'b0;
        for (int c = 1; c <= 40 && got < 8; c++) begin
            ordy = !(c >= 2 && c <= 7);
            iv   = (sent < 8);
            if (sent < 8) begin
                a = bp_a[sent]; b = bp_b[sent]; sg = bp_s[sent]; tg = 4'(sent);
            end
            @(negedge clk);
            if (hold_v) begin
                chk("bp_hold_res", ores, hold_r);
                chk("bp_hold_tag", otg, hold_t);
            end
            if (sent == 3 && !ordy) chk("bp_full", ir, 0);
            if (iv && ir) begin
                eq_r.push_back(ref64(a, b, sg));
                eq_t.push_back(tg);
                sent++;
            end
            if (ov && ordy) begin
                chk("bp_res", ores, eq_r.pop_front());
                chk("bp_tag", otg, eq_t.pop_front());
                got++;
            end
            hold_v = ov && !ordy; hold_r = ores; hold_t = otg;
            tick();
        end
        iv = 1'b0;
        chk("bp_count", got, 8);

        // ---- bubble collapse ----
        ordy = 1'b0; acc = 0;
        eq_r.delete(); eq_t.delete();
        for (int c = 0; c < 12; c++) begin
            iv = (c == 0 || c == 3 || c == 5 || c >= 8);
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; sg = 1'($urandom); tg = 4'(8 + acc);
            @(negedge clk);
            if (iv && ir) begin
                eq_r.push_back(ref64(a, b, sg));
                eq_t.push_back(tg);
                acc++;
            end
            tick();
        end
        iv = 1'b0;
        chk("bub_acc", acc, 3);
        @(negedge clk);
        chk("bub_full", ir, 0);
        chk("bub_ov", ov, 1);
        tick();
        ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bub_drain_v", ov, 1);
            if (eq_r.size() > 0) begin
                chk("bub_res", ores, eq_r.pop_front());
                chk("bub_tag", otg, eq_t.pop_front());
            end
            tick();
        end
        @(negedge clk);
        chk("bub_empty", ov, 0);
        tick();

        // ---- reset with two ops in flight ----
        ordy = 1'b1; iv = 1'b1; a = 64'd7; b = 64'd9; sg = 1'b0; tg = 4'h1;
        tick();
        a = 64'd11; b = 64'd13; tg = 4'h2;
        tick();
        rst_n = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("rmid_ir", ir, 0);
        tick();
        @(negedge clk);
        chk("rmid_ov", ov, 0);
        chk("rmid_res", ores, 0);
        chk("rmid_tag", otg, 0);
        rst_n = 1'b1;
        tick();
        run1("post_rst", 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 1'b1, 4'h9, ref64(64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 1'b1));

        // ---- 8-bit random traffic ----
        mon8 = 1'b1;
        for (int c = 0; c < 16000; c++) begin
            iv8   = ($urandom_range(0, 9) < 7);
            ordy8 = ($urandom_range(0, 9) < 7);
            a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom); tg8 = 4'($urandom);
            tick();
        end

        // ---- 8-bit sweep: corner a against every b, both signedness ----
        ordy8 = 1'b1;
        iv8   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ca[6];
            ca = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
            for (int bb = 0; bb < 256; bb++) begin
                for (int s = 0; s < 2; s++) begin
                    iv8 = 1'b1; a8 = ca[k]; b8 = 8'(bb); sg8 = 1'(s); tg8 = 4'(bb + s);
                    tick();
                end
            end
        end
        iv8 = 1'b0;
        for (int w = 0; w < 20 && q8r.size() != 0; w++) tick();
        chk("w8_drained", q8r.size(), 0);
        mon8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=done", n_chk);
        $fatal(1, "timeout");
    end

endmodule
